// File: rtl/cpu_bus_responder.sv
// rtl/cpu_bus_responder.sv - memory-side responder and store tracer for the cpu6502 bus
//
// Supplies registered read data for RAM, the NMI/RESET/IRQ vectors and unmapped
// space, commits CPU stores on the falling edge of phi2 and logs every commit
// into a show-ahead trace FIFO.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   addr, wdata, rw CPU bus (rw: 1 = read, 0 = write)
//   clk2            CPU phi2
//   rdata           read data, one clk after addr
//   write_strobe    one-cycle pulse in the cycle a store commits
//   trace_*         store-trace FIFO head, pop, occupancy and sticky overflow
module cpu_bus_responder #(
  parameter int          RAM_AW      = 11,
  parameter int          TRACE_DEPTH = 16,
  parameter logic [15:0] NMI_VEC     = 16'h0000,
  parameter logic [15:0] RESET_VEC   = 16'h0000,
  parameter logic [15:0] IRQ_VEC     = 16'h0000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [15:0]                      addr,
  input  logic [7:0]                       wdata,
  output logic [7:0]                       rdata,
  input  logic                             rw,
  input  logic                             clk2,
  output logic                             write_strobe,
  output logic                             trace_valid,
  output logic [15:0]                      trace_addr,
  output logic [7:0]                       trace_data,
  input  logic                             trace_pop,
  output logic [$clog2(TRACE_DEPTH+1)-1:0] trace_count,
  output logic                             trace_ovf
);

  localparam int PW = $clog2(TRACE_DEPTH);
  localparam int CW = $clog2(TRACE_DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(TRACE_DEPTH);

  logic [7:0] mem [2**RAM_AW];

  // ---------------- read path ----------------
  logic [7:0] rd_next;

  always_comb begin
    rd_next = 8'hFF;
    if (addr[15:RAM_AW] == '0) begin
      rd_next = mem[addr[RAM_AW-1:0]];
    end else begin
      case (addr)
        16'hFFFA: rd_next = NMI_VEC[7:0];
        16'hFFFB: rd_next = NMI_VEC[15:8];
        16'hFFFC: rd_next = RESET_VEC[7:0];
        16'hFFFD: rd_next = RESET_VEC[15:8];
        16'hFFFE: rd_next = IRQ_VEC[7:0];
        16'hFFFF: rd_next = IRQ_VEC[15:8];
        default:  rd_next = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rdata <= 8'hFF;
    else       rdata <= rd_next;
  end

  // ---------------- store capture / commit ----------------
  // The bus is sampled while phi2 is high; the commit at the phi2 fall uses
  // these copies because the CPU may already be moving addr as phi2 drops.
  logic        clk2_q;
  logic        cap_wr;
  logic [15:0] cap_addr;
  logic [7:0]  cap_data;
  logic        commit;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk2_q   <= 1'b0;
      cap_wr   <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
    end else begin
      clk2_q <= clk2;
      if (clk2) begin
        cap_wr <= ~rw;
        if (!rw) begin
          cap_addr <= addr;
          cap_data <= wdata;
        end
      end
    end
  end

  // A falling phi2 happens once per high period, so this fires once per store.
  assign commit       = ~reset & clk2_q & ~clk2 & cap_wr;
  assign write_strobe = commit;

  // Writes outside the RAM window are traced but leave memory alone.
  always_ff @(posedge clk) begin
    if (commit && cap_addr[15:RAM_AW] == '0)
      mem[cap_addr[RAM_AW-1:0]] <= cap_data;
  end

  // ---------------- store-trace FIFO ----------------
  logic [15:0]   fifo_addr [TRACE_DEPTH];
  logic [7:0]    fifo_data [TRACE_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          pop_en;
  logic          push_en;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign pop_en  = trace_pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_en = commit & (~full | pop_en);

  always_ff @(posedge clk) begin
    if (push_en) begin
      fifo_addr[wr_ptr] <= cap_addr;
      fifo_data[wr_ptr] <= cap_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      trace_ovf <= 1'b0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PW'(1);
      if (commit && !push_en) trace_ovf <= 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign trace_valid = ~empty;
  assign trace_count = count;
  assign trace_addr  = fifo_addr[rd_ptr];
  assign trace_data  = fifo_data[rd_ptr];

endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb/tb_cpu_bus_responder.sv - self-checking bench for cpu_bus_responder
module tb_cpu_bus_responder;

  localparam int DEPTH = 16;
  localparam logic [15:0] IRQ_V = 16'hABCD;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rw;
  logic        clk2;
  logic        write_strobe;
  logic        trace_valid;
  logic [15:0] trace_addr;
  logic [7:0]  trace_data;
  logic        trace_pop;
  logic [4:0]  trace_count;
  logic        trace_ovf;

  int checks = 0;
  int failures = 0;

  cpu_bus_responder #(.IRQ_VEC(IRQ_V)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .rdata(rdata),
    .rw(rw), .clk2(clk2), .write_strobe(write_strobe),
    .trace_valid(trace_valid), .trace_addr(trace_addr), .trace_data(trace_data),
    .trace_pop(trace_pop), .trace_count(trace_count), .trace_ovf(trace_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_mem [0:2047];
  bit          m_known [0:2047];
  logic [23:0] m_q [$];
  bit          m_on = 0;
  bit          m_ovf, m_phi_prev, m_store_pending;
  logic [15:0] m_st_addr;
  logic [7:0]  m_st_data;
  logic [7:0]  m_rdata;
  bit          m_rknown;

  function automatic logic [7:0] vec_byte(input logic [15:0] a);
    logic [15:0] v;
    case (a[2:1])
      2'b01:   v = 16'h0000;
      2'b10:   v = 16'h0000;
      default: v = IRQ_V;
    endcase
    return a[0] ? v[15:8] : v[7:0];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_on = 1; m_ovf = 0; m_phi_prev = 0; m_store_pending = 0;
      m_q.delete(); m_rdata = 8'hFF; m_rknown = 1;
    end else begin
      // read sees memory as it was before this edge's store
      if (addr < 16'h0800) begin
        m_rdata = m_mem[addr[10:0]]; m_rknown = m_known[addr[10:0]];
      end else if (addr >= 16'hFFFA) begin
        m_rdata = vec_byte(addr); m_rknown = 1;
      end else begin
        m_rdata = 8'hFF; m_rknown = 1;
      end
      if (m_phi_prev && !clk2 && m_store_pending) begin
        if (m_st_addr < 16'h0800) begin
          m_mem[m_st_addr[10:0]] = m_st_data; m_known[m_st_addr[10:0]] = 1;
        end
        if (trace_pop && m_q.size() > 0) void'(m_q.pop_front());
        if (m_q.size() < DEPTH) m_q.push_back({m_st_addr, m_st_data});
        else m_ovf = 1;
      end else if (trace_pop && m_q.size() > 0) begin
        void'(m_q.pop_front());
      end
      if (clk2) begin
        m_store_pending = !rw;
        if (!rw) begin m_st_addr = addr; m_st_data = wdata; end
      end
      m_phi_prev = clk2;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      if (m_rknown) chk("rdata", rdata, m_rdata);
      chk("write_strobe", write_strobe, !reset && m_phi_prev && !clk2 && m_store_pending);
      chk("trace_valid", trace_valid, m_q.size() != 0);
      chk("trace_count", trace_count, m_q.size());
      chk("trace_ovf", trace_ovf, m_ovf);
      if (m_q.size() != 0) chk("trace_head", {trace_addr, trace_data}, m_q[0]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; cyc(2); reset = 0;
  endtask

  task automatic store(input logic [15:0] a, input logic [7:0] d, input logic pop);
    clk2 = 1; rw = 0; addr = a; wdata = d;
    cyc(2);
    clk2 = 0; rw = 1; addr = 16'h2000; wdata = 8'h00; trace_pop = pop;
    #1;
    chk("store_strobe", write_strobe, 1);
    @(posedge clk); #1;
    trace_pop = 0;
  endtask

  task automatic pop1();
    trace_pop = 1; cyc(1); trace_pop = 0;
  endtask

  task automatic read_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
    addr = a; cyc(1);
    chk(name, rdata, exp);
  endtask

  initial begin
    reset = 1; addr = 16'h2000; wdata = 0; rw = 1; clk2 = 0; trace_pop = 0;
    cyc(2);
    chk("reset_rdata", rdata, 8'hFF);
    chk("reset_count", trace_count, 0);
    chk("reset_valid", trace_valid, 0);
    reset = 0;

    read_chk("vec_FFFC", 16'hFFFC, 8'h00);
    read_chk("vec_FFFD", 16'hFFFD, 8'h00);
    read_chk("unmapped_1234", 16'h1234, 8'hFF);
    read_chk("irq_FFFF", 16'hFFFF, 8'hAB);
    read_chk("irq_FFFE", 16'hFFFE, 8'hCD);

    store(16'h0099, 8'h01, 0);
    chk("st_strobe_off", write_strobe, 0);
    chk("st_valid", trace_valid, 1);
    chk("st_head", {trace_addr, trace_data}, 24'h009901);
    read_chk("st_readback", 16'h0099, 8'h01);
    pop1();
    chk("st_popped", trace_valid, 0);

    store(16'hFFFC, 8'h55, 0);
    chk("vec_store_head", {trace_addr, trace_data}, 24'hFFFC55);
    read_chk("vec_store_read", 16'hFFFC, 8'h00);
    pop1();

    for (int i = 0; i <= 16; i++) store(16'h0100 + 16'(i), 8'(i), 0);
    chk("ovf_count", trace_count, 16);
    chk("ovf_flag", trace_ovf, 1);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_order", {trace_addr, trace_data}, {16'h0100 + 16'(i), 8'(i)});
      pop1();
    end
    chk("ovf_drained", trace_valid, 0);
    chk("ovf_sticky", trace_ovf, 1);

    do_reset();
    chk("post_reset_ovf", trace_ovf, 0);
    for (int i = 0; i < 16; i++) store(16'h0200 + 16'(i), 8'(i), 0);
    store(16'h0300, 8'hAA, 1);
    chk("full_pp_count", trace_count, 16);
    chk("full_pp_ovf", trace_ovf, 0);
    chk("full_pp_head", {trace_addr, trace_data}, 24'h020101);

    do_reset();
    store(16'h0010, 8'h33, 0);
    pop1();
    clk2 = 1; rw = 0; addr = 16'h0010; wdata = 8'h77;
    cyc(2);
    reset = 1; cyc(1);
    clk2 = 0; rw = 1; addr = 16'h2000;
    #1;
    chk("rst_store_strobe", write_strobe, 0);
    cyc(1);
    reset = 0; cyc(2);
    chk("rst_store_strobe2", write_strobe, 0);
    chk("rst_store_count", trace_count, 0);
    read_chk("rst_store_mem", 16'h0010, 8'h33);

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
